// File: rtl/ether_rx.sv
// RMII receive front end: finds preamble + SFD on the dibit stream, strips them,
// and forwards the frame body (DA through FCS) with a valid qualifier.
module ether_rx #(
  parameter int MIN_PREAMBLE = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(MIN_PREAMBLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MIN_PREAMBLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             axiov_q, axiov_d;
  logic [1:0]       axiod_q, axiod_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (crsdv) begin
          if (rxd == DIBIT_PRE) begin
            state_d = PREAMBLE;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = DROP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PREAMBLE: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else if (rxd == DIBIT_PRE) begin
          // Saturate so an over-long preamble still qualifies.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else if ((rxd == DIBIT_SFD) && (cnt_q >= CNT_MAX)) begin
          state_d = DATA;
        end else begin
          state_d = DROP;
        end
      end
      DATA, DROP: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_comb begin
    axiov_d     = 1'b0;
    axiod_d     = axiod_q;
    frame_err_d = 1'b0;
    case (state_q)
      PREAMBLE: begin
        if (!crsdv) begin
          frame_err_d = 1'b1;
        end else if (rxd == DIBIT_PRE) begin
          frame_err_d = 1'b0;
        end else if ((rxd == DIBIT_SFD) && (cnt_q >= CNT_MAX)) begin
          frame_err_d = 1'b0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      DATA: begin
        if (crsdv) begin
          axiov_d = 1'b1;
          axiod_d = rxd;
        end else begin
          axiov_d = 1'b0;
        end
      end
      default: begin
        axiov_d     = 1'b0;
        frame_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      axiov_q     <= 1'b0;
      axiod_q     <= 2'b00;
      frame_err_q <= 1'b0;
    end else begin
      axiov_q     <= axiov_d;
      axiod_q     <= axiod_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign axiov     = axiov_q;
  assign axiod     = axiod_q;
  assign frame_err = frame_err_q;

endmodule
